// File: rtl/fft_output_reorder_if.sv
// Bus bundle between the FFT core output, the reorder buffer and the
// downstream PUSCH chain. The master drives samples and out_ready.
// The slave (the reorder block) drives the natural-order stream.
interface fft_output_reorder_if #(
  parameter int WIDTH = 18,
  parameter int AW    = 11
);
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             in_en;
  logic [AW-1:0]    in_addr;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_index;
  logic             out_last;

  modport master (
    output in_re, in_im, in_en, in_addr, out_ready,
    input  out_re, out_im, out_valid, out_index, out_last
  );

  modport slave (
    input  in_re, in_im, in_en, in_addr, out_ready,
    output out_re, out_im, out_valid, out_index, out_last
  );
endinterface

// File: rtl/fft_output_reorder.sv
// FFT output reorder buffer. Scrambled-order samples tagged with a bin
// address are collected into a frame buffer. Once all N bins have arrived,
// the frame is streamed out in natural order over valid/ready.
// Optional feature: define DUP_CHECK_EN to reject writes to an occupied bin
// (occupancy bitmap, dup_err flag). Without it, a duplicate overwrites the
// bin and still counts toward the frame.
//
// state   | meaning
// COLLECT | accept input samples into the buffer, count writes up to N
// DRAIN   | read the buffer 0..N-1 out over valid/ready, drop input samples
module fft_output_reorder #(
  parameter int WIDTH = 18,
  parameter int N     = 1200,
  parameter int AW    = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_output_reorder_if.slave  bus,
  output logic                 busy,
  output logic                 ovf_err,
  output logic                 range_err,
  output logic                 dup_err
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DRAIN   = 1'b1;

  // Counters carry one extra bit so N itself is representable when N == 2**AW.
  localparam logic [AW:0] N_W    = (AW+1)'(N);
  localparam logic [AW:0] LAST_W = (AW+1)'(N - 1);

  logic [0:0]         state;
  logic [AW:0]        count;
  logic [AW:0]        rd_ptr;
  logic [2*WIDTH-1:0] mem [N];
  logic [2*WIDTH-1:0] mem_q;
  logic               q_valid;
  logic [AW:0]        q_idx;

  logic in_range;
  logic dup_hit;
  logic wr_en;
  logic out_adv;
  logic rd_en;
  logic done;

  assign in_range = ({1'b0, bus.in_addr} < N_W);

`ifdef DUP_CHECK_EN
  logic [N-1:0] occ;

  assign dup_hit = (state == COLLECT) && bus.in_en && in_range && occ[bus.in_addr];

  // Occupancy bitmap: set on accepted writes, cleared when the frame leaves.
  always_ff @(posedge clk) begin
    if (reset || done) begin
      occ <= '0;
    end else if (wr_en) begin
      occ[bus.in_addr] <= 1'b1;
    end
  end

  // Sticky duplicate-bin flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      dup_err <= 1'b0;
    end else if (dup_hit) begin
      dup_err <= 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
  assign dup_err = 1'b0;
`endif

  assign wr_en   = (state == COLLECT) && bus.in_en && in_range && !dup_hit;
  // Output register is free when empty or being consumed this cycle.
  assign out_adv = !bus.out_valid || bus.out_ready;
  // Only fetch when the read-data stage will be free to take the result.
  assign rd_en   = (state == DRAIN) && (rd_ptr < N_W) && (!q_valid || out_adv);
  assign done    = (state == DRAIN) && bus.out_valid && bus.out_ready && bus.out_last;
  assign busy    = (state == DRAIN);

  // Frame buffer: writes only in COLLECT, synchronous reads only in DRAIN.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bus.in_addr] <= {bus.in_re, bus.in_im};
    end
    if (rd_en) begin
      mem_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Frame sequencing: count accepted writes, switch to DRAIN on the Nth.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      count <= '0;
    end else if (state == COLLECT) begin
      if (wr_en) begin
        if (count == LAST_W) begin
          state <= DRAIN;
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end else if (done) begin
      state <= COLLECT;
    end
  end

  // Read pipeline: address pointer and the read-data stage valid/index.
  always_ff @(posedge clk) begin
    if (reset || done) begin
      rd_ptr  <= '0;
      q_valid <= 1'b0;
      q_idx   <= '0;
    end else if (rd_en) begin
      rd_ptr  <= rd_ptr + 1'b1;
      q_valid <= 1'b1;
      q_idx   <= rd_ptr;
    end else if (out_adv) begin
      q_valid <= 1'b0;
    end
  end

  // Output register: loads from the read stage, holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
    end else if (done) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else if ((state == DRAIN) && out_adv) begin
      bus.out_valid <= q_valid;
      if (q_valid) begin
        bus.out_re    <= mem_q[2*WIDTH-1:WIDTH];
        bus.out_im    <= mem_q[WIDTH-1:0];
        bus.out_index <= q_idx[AW-1:0];
        bus.out_last  <= (q_idx == LAST_W);
      end
    end
  end

  // Sticky input error flags; the offending samples are simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_err   <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (bus.in_en && (state == DRAIN)) begin
        ovf_err <= 1'b1;
      end
      if (bus.in_en && !in_range) begin
        range_err <= 1'b1;
      end
    end
  end

endmodule
